uncached_store_tracker: RTL and testbench
=========================================

Name: uncached_store_tracker

Overview:
- Tracks uncached/non-idempotent stores between the CVA6 store unit and the AXI write channel.
- Throttles issue at a configured maximum: MaxOutstandingUncachedStores, 7 in the dual-hart write-back configuration.
- Keeps per-AXI-ID outstanding counts, checks B responses for consistency, and implements fence drain (stall new issues, acknowledge once all responses have returned).

Parameters:
MaxOutstanding, 7, maximum uncached stores in flight (>=1)
AxiIdWidth, 4, AXI write ID width; per-ID counters for 2**AxiIdWidth IDs
CntWidth, $clog2(MaxOutstanding+1), counter width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
issue_valid_i  in  1  store unit requests to issue an uncached store (AW)
issue_id_i  in  AxiIdWidth  AXI ID of the store
issue_ready_o  out  1  issue accepted when valid&ready
resp_valid_i  in  1  B response beat (always accepted, no backpressure)
resp_id_i  in  AxiIdWidth  BID
resp_err_i  in  1  BRESP is SLVERR/DECERR
fence_req_i  in  1  single-cycle fence request
fence_ack_o  out  1  single-cycle pulse: all prior stores have responded
count_o  out  CntWidth  total outstanding stores (registered)
empty_o  out  1  count_o==0
full_o  out  1  count_o==MaxOutstanding
bus_err_o  out  1  pulse, registered: response with resp_err_i for a tracked ID
spurious_o  out  1  pulse, registered: response for an ID with zero outstanding

Behaviour:
- Clocking and reset: one clock (clk_i). rst_i is synchronous and active-high.
- Reset values: count=0; all per-ID counts=0; FSM=IDLE; fence_ack_o=0; bus_err_o=0; spurious_o=0; empty_o=1; full_o=0.
- issue_ready_o = (state==IDLE) & (count_q < MaxOutstanding).
  - Depends only on registered state; there is no combinational path from resp_valid_i or fence_req_i.
  - Consequence: when full, a response in the same cycle does not open ready until the next cycle.
- Issue fire (issue_valid_i & issue_ready_o): count +1; id_cnt[issue_id_i] +1.
- Valid response (resp_valid_i & id_cnt[resp_id_i]!=0): count -1; id_cnt[resp_id_i] -1.
  - bus_err_o=resp_err_i on the next cycle.
- Spurious response (resp_valid_i & id_cnt[resp_id_i]==0): no counter change; spurious_o=1 on the next cycle.
  - Evaluated on pre-update values, even if the same ID is issued in the same cycle.
- Simultaneous issue and valid response in one cycle:
  - count unchanged.
  - Same ID: id_cnt unchanged.
  - Different IDs: one +1 and one -1.
- Counters never wrap. Total is bounded by MaxOutstanding via ready. Per-ID count <= total.
- FSM:
  - IDLE: fence_req_i -> DRAIN. An issue fire in the same cycle is still accepted and is included in the drain.
  - DRAIN: issue_ready_o=0. When count_q==0 (registered) -> ACK.
  - ACK: fence_ack_o=1 for exactly this cycle; issue_ready_o=0; next state IDLE.
- fence_req_i while not in IDLE is ignored; the single outstanding ack covers it.
- Latency:
  - Fence with count 0 and no same-cycle issue: ack 2 cycles after the request (request at T, DRAIN at T+1, ack at T+2).
  - Otherwise: ack 2 cycles after the cycle in which the last response is sampled.
- Responses with an error still decrement; error signalling is advisory only.
- Reset mid-drain: returns to IDLE with all counts cleared. No ack is produced for the abandoned fence.

Test Plan:
- Reset, then issue 7 stores ID 0..6 back-to-back -> ready high cycles 0-6; full_o=1 and issue_ready_o=0 from cycle 7; count_o=7.
- Full; response ID 3 and issue_valid_i in the same cycle -> issue not accepted that cycle; count_o=6 next cycle; issue accepted the cycle after, count_o=7.
- Issue ID 5 and response ID 5 in the same cycle with id_cnt[5]=1 -> count_o and id_cnt[5] unchanged; no spurious_o.
- Response ID 9 with nothing outstanding on ID 9 -> spurious_o pulse 1 cycle later; count_o unchanged.
- 3 outstanding, fence at T, responses at T+2/T+4/T+6 -> issue_ready_o=0 from T+1; fence_ack_o single pulse at T+8; ready returns T+9.
- Fence with count 0 at T -> fence_ack_o at T+2. Second fence at T+1 -> ignored, only one ack.
- Response with resp_err_i=1 for a tracked ID -> bus_err_o pulse; count decrements.
- Reset asserted in DRAIN -> count_o=0, IDLE, no fence_ack_o.

Source files
------------

// File: rtl/uncached_store_tracker_if.sv
// Purpose : handshake/status bundle between the store unit, the B channel and the
//           uncached store tracker.
// Ports   : issue (valid/ready/id), B response (valid/id/err), fence req/ack,
//           status (count/empty/full) and the registered error/spurious pulses.
//           The master modport is the store-unit/bus side; the slave modport is
//           the tracker.
interface uncached_store_tracker_if #(
   parameter int MaxOutstanding = 7,
   parameter int AxiIdWidth     = 4
);
   localparam int CntWidth = $clog2(MaxOutstanding + 1);

   logic                  issue_valid_i;
   logic [AxiIdWidth-1:0] issue_id_i;
   logic                  issue_ready_o;
   logic                  resp_valid_i;
   logic [AxiIdWidth-1:0] resp_id_i;
   logic                  resp_err_i;
   logic                  fence_req_i;
   logic                  fence_ack_o;
   logic [CntWidth-1:0]   count_o;
   logic                  empty_o;
   logic                  full_o;
   logic                  bus_err_o;
   logic                  spurious_o;

   modport master (
      output issue_valid_i, issue_id_i, resp_valid_i, resp_id_i, resp_err_i, fence_req_i,
      input  issue_ready_o, fence_ack_o, count_o, empty_o, full_o, bus_err_o, spurious_o
   );

   modport slave (
      input  issue_valid_i, issue_id_i, resp_valid_i, resp_id_i, resp_err_i, fence_req_i,
      output issue_ready_o, fence_ack_o, count_o, empty_o, full_o, bus_err_o, spurious_o
   );
endinterface

// File: rtl/uncached_store_tracker.sv
// Purpose     : tracks in-flight uncached stores (total and per AXI ID), flags B
//               responses that are erroneous or have no matching store, and drains
//               on a fence.
// Latency     : counts and error/spurious pulses appear the cycle after the event;
//               fence ack two cycles after the request (empty) or after the last
//               response is sampled.
// Backpressure: issue_ready_o drops when MaxOutstanding stores are in flight or a
//               fence is pending; responses are always accepted.
// Ports       : clk_i, rst_i (synchronous, active-high) plus the slave side of
//               uncached_store_tracker_if.
module uncached_store_tracker #(
   parameter int MaxOutstanding = 7,
   parameter int AxiIdWidth     = 4
) (
   input logic                     clk_i,
   input logic                     rst_i,
   uncached_store_tracker_if.slave bus
);
   localparam int                  CntWidth = $clog2(MaxOutstanding + 1);
   localparam int                  NumIds   = 1 << AxiIdWidth;
   localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      ACK   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] count_q, count_d;
   logic [CntWidth-1:0] id_cnt_q [NumIds];
   logic [CntWidth-1:0] id_cnt_d [NumIds];
   logic                bus_err_q, bus_err_d;
   logic                spurious_q, spurious_d;

   logic issue_ready;
   logic issue_fire;
   logic resp_tracked;
   logic resp_hit;
   logic resp_spur;

   // Ready is a function of registered state only, so a response arriving while
   // full frees a slot one cycle later rather than through a combinational path.
   assign issue_ready = (state_q == IDLE) && (count_q < MaxCnt);
   assign issue_fire  = bus.issue_valid_i && issue_ready;

   // Classification uses the pre-update per-ID count, so a response for an ID
   // being issued this same cycle is still spurious if nothing was outstanding.
   assign resp_tracked = (id_cnt_q[bus.resp_id_i] != '0);
   assign resp_hit     = bus.resp_valid_i && resp_tracked;
   assign resp_spur    = bus.resp_valid_i && !resp_tracked;

   // Counter next-state
   always_comb begin
      count_d    = count_q;
      id_cnt_d   = id_cnt_q;
      bus_err_d  = resp_hit && bus.resp_err_i;
      spurious_d = resp_spur;

      // Applied in sequence: an issue and response on the same ID cancel out.
      if (issue_fire) begin
         id_cnt_d[bus.issue_id_i] = id_cnt_d[bus.issue_id_i] + 1'b1;
      end
      if (resp_hit) begin
         id_cnt_d[bus.resp_id_i] = id_cnt_d[bus.resp_id_i] - 1'b1;
      end

      unique case ({issue_fire, resp_hit})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Fence FSM next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            // A store issued alongside the fence is already in count_d and is
            // therefore covered by the drain.
            if (bus.fence_req_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (count_q == '0) begin
               state_d = ACK;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         count_q    <= '0;
         bus_err_q  <= 1'b0;
         spurious_q <= 1'b0;
         for (int i = 0; i < NumIds; i++) begin
            id_cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         bus_err_q  <= bus_err_d;
         spurious_q <= spurious_d;
         for (int i = 0; i < NumIds; i++) begin
            id_cnt_q[i] <= id_cnt_d[i];
         end
      end
   end

   assign bus.issue_ready_o = issue_ready;
   assign bus.fence_ack_o   = (state_q == ACK);
   assign bus.count_o       = count_q;
   assign bus.empty_o       = (count_q == '0);
   assign bus.full_o        = (count_q == MaxCnt);
   assign bus.bus_err_o     = bus_err_q;
   assign bus.spurious_o    = spurious_q;
endmodule

// File: tb/tb_uncached_store_tracker.sv
// Purpose : self-checking bench for uncached_store_tracker: directed scenarios with
//           literal expectations, then randomized traffic against a behavioural model.
// Ports   : none; instantiates the interface and the tracker.
module tb_uncached_store_tracker;
   localparam int MAX  = 7;
   localparam int IDW  = 4;
   localparam int NIDS = 1 << IDW;

   logic clk;
   logic rst;
   int   n_cmp  = 0;
   int   n_fail = 0;

   uncached_store_tracker_if #(.MaxOutstanding(MAX), .AxiIdWidth(IDW)) bus ();

   uncached_store_tracker #(.MaxOutstanding(MAX), .AxiIdWidth(IDW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit iv, input int iid, input bit rv, input int rid,
                        input bit err, input bit fr);
      bus.issue_valid_i = iv;
      bus.issue_id_i    = IDW'(iid);
      bus.resp_valid_i  = rv;
      bus.resp_id_i     = IDW'(rid);
      bus.resp_err_i    = err;
      bus.fence_req_i   = fr;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   // Outstanding stores are kept as plain per-ID integers; a fence blocks issue
   // from the request until its ack cycle has passed.
   int m_cnt [NIDS];
   int m_total;
   bit m_blocked, m_ack, m_berr, m_spur, m_valid;

   initial begin
      m_valid = 1'b0;
      forever begin
         @(posedge clk);
         begin
            bit iv, rv, err, fr, fire, hit, new_ack;
            int iid, rid, tot_pre;
            iv  = bus.issue_valid_i;
            iid = int'(bus.issue_id_i);
            rv  = bus.resp_valid_i;
            rid = int'(bus.resp_id_i);
            err = bus.resp_err_i;
            fr  = bus.fence_req_i;
            if (rst) begin
               foreach (m_cnt[i]) m_cnt[i] = 0;
               m_total   = 0;
               m_blocked = 1'b0;
               m_ack     = 1'b0;
               m_berr    = 1'b0;
               m_spur    = 1'b0;
               m_valid   = 1'b1;
            end else if (m_valid) begin
               tot_pre = m_total;
               fire    = iv && !m_blocked && (m_total < MAX);
               hit     = rv && (m_cnt[rid] > 0);
               m_spur  = rv && (m_cnt[rid] == 0);
               m_berr  = hit && err;
               new_ack = 1'b0;
               if (m_ack)          m_blocked = 1'b0;       // ack cycle over
               else if (m_blocked) new_ack = (tot_pre == 0); // all earlier stores back
               else if (fr)        m_blocked = 1'b1;
               m_ack = new_ack;
               if (fire) begin m_cnt[iid]++; m_total++; end
               if (hit)  begin m_cnt[rid]--; m_total--; end
            end
         end
         #1;
         if (m_valid) begin
            chk("m_count",    32'(bus.count_o),    32'(m_total));
            chk("m_empty",    32'(bus.empty_o),    32'(m_total == 0));
            chk("m_full",     32'(bus.full_o),     32'(m_total == MAX));
            chk("m_ready",    32'(bus.issue_ready_o), 32'(!m_blocked && m_total < MAX));
            chk("m_ack",      32'(bus.fence_ack_o), 32'(m_ack));
            chk("m_bus_err",  32'(bus.bus_err_o),  32'(m_berr));
            chk("m_spurious", 32'(bus.spurious_o), 32'(m_spur));
         end
      end
   end

   // ---------------- stimulus with literal expectations ----------------
   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      chk("rst_count", 32'(bus.count_o), 0);
      chk("rst_empty", 32'(bus.empty_o), 1);
      chk("rst_full",  32'(bus.full_o),  0);
      chk("rst_ready", 32'(bus.issue_ready_o), 1);
      chk("rst_ack",   32'(bus.fence_ack_o), 0);
      rst = 1'b0;

      // Fill to the limit with IDs 0..6.
      for (int i = 0; i < MAX; i++) begin
         chk("fill_ready", 32'(bus.issue_ready_o), 1);
         drive(1, i, 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("fill_count", 32'(bus.count_o), 7);
      chk("fill_full",  32'(bus.full_o), 1);
      chk("fill_ready0", 32'(bus.issue_ready_o), 0);

      // Response while full does not open ready in the same cycle.
      drive(1, 7, 1, 3, 0, 0);
      chk("full_resp_ready", 32'(bus.issue_ready_o), 0);
      tick();
      chk("full_resp_count", 32'(bus.count_o), 6);
      chk("full_resp_ready1", 32'(bus.issue_ready_o), 1);
      drive(1, 7, 0, 0, 0, 0);
      tick();
      chk("refill_count", 32'(bus.count_o), 7);

      // Free a slot, then issue + respond on ID 5 together.
      drive(0, 0, 1, 0, 0, 0);
      tick();
      chk("free_count", 32'(bus.count_o), 6);
      drive(1, 5, 1, 5, 0, 0);
      tick();
      chk("same_id_count", 32'(bus.count_o), 6);
      chk("same_id_spur",  32'(bus.spurious_o), 0);
      drive(0, 0, 1, 5, 0, 0);
      tick();
      chk("id5_count", 32'(bus.count_o), 5);
      chk("id5_spur",  32'(bus.spurious_o), 0);
      drive(0, 0, 1, 5, 0, 0);
      tick();
      chk("id5_empty_spur",  32'(bus.spurious_o), 1);
      chk("id5_empty_count", 32'(bus.count_o), 5);

      // Response on an ID that never had a store.
      drive(0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 1, 9, 0, 0);
      tick();
      chk("id9_spur",  32'(bus.spurious_o), 1);
      chk("id9_count", 32'(bus.count_o), 5);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("id9_spur_clr", 32'(bus.spurious_o), 0);

      // Error response still decrements.
      drive(0, 0, 1, 1, 1, 0);
      tick();
      chk("err_pulse", 32'(bus.bus_err_o), 1);
      chk("err_count", 32'(bus.count_o), 4);
      drive(0, 0, 1, 2, 0, 0);
      tick();
      chk("err_clr",   32'(bus.bus_err_o), 0);
      chk("pre_fence_count", 32'(bus.count_o), 3);

      // Fence with IDs 4, 6, 7 outstanding; responses at T+2/T+4/T+6.
      drive(0, 0, 0, 0, 0, 1);
      tick();
      for (int t = 1; t <= 9; t++) begin
         chk("drain_ready", 32'(bus.issue_ready_o), 32'(t >= 9));
         chk("drain_ack",   32'(bus.fence_ack_o),   32'(t == 8));
         if (t == 7) chk("drain_count", 32'(bus.count_o), 0);
         case (t)
            2:       drive(0, 0, 1, 4, 0, 0);
            4:       drive(0, 0, 1, 6, 0, 0);
            6:       drive(0, 0, 1, 7, 0, 0);
            default: drive(0, 0, 0, 0, 0, 0);
         endcase
         tick();
      end

      // Empty fence, second request one cycle later is absorbed.
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk("f0_ack1",   32'(bus.fence_ack_o), 0);
      chk("f0_ready1", 32'(bus.issue_ready_o), 0);
      drive(0, 0, 0, 0, 0, 1);
      tick();
      chk("f0_ack2", 32'(bus.fence_ack_o), 1);
      drive(0, 0, 0, 0, 0, 0);
      for (int t = 3; t <= 6; t++) begin
         tick();
         chk("f0_ack_once", 32'(bus.fence_ack_o), 0);
      end
      chk("f0_ready_back", 32'(bus.issue_ready_o), 1);

      // Reset while draining.
      drive(1, 2, 0, 0, 0, 0);
      tick();
      drive(1, 3, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("rd_count", 32'(bus.count_o), 2);
      chk("rd_ready", 32'(bus.issue_ready_o), 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rd_count0", 32'(bus.count_o), 0);
      chk("rd_ready1", 32'(bus.issue_ready_o), 1);
      for (int t = 0; t < 5; t++) begin
         chk("rd_no_ack", 32'(bus.fence_ack_o), 0);
         tick();
      end

      // Randomized traffic; mostly a few IDs so responses usually match.
      for (int n = 0; n < 4000; n++) begin
         bit iv, rv, err, fr;
         int iid, rid;
         iv  = ($urandom % 3) != 0;
         iid = (($urandom % 8) == 0) ? int'($urandom % NIDS) : int'($urandom % 4);
         rv  = ($urandom % 2) != 0;
         rid = (($urandom % 8) == 0) ? int'($urandom % NIDS) : int'($urandom % 4);
         err = ($urandom % 8) == 0;
         fr  = ($urandom % 40) == 0;
         rst = ($urandom % 500) == 0;
         drive(iv, iid, rv, rid, err, fr);
         tick();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
